// File: rtl/ifft16_pkg.sv
// Shared constants for the 16-point streaming inverse DFT: block geometry,
// controller state encoding and the Q2.14 twiddle ROM W[i] = exp(+j*2*pi*i/16).
package ifft16_pkg;

  localparam int N       = 16;
  localparam int LOG2N   = 4;
  localparam int TW_FRAC = 14;
  localparam int TW_W    = TW_FRAC + 2;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  // cos(2*pi*i/16) scaled by 2^14 and rounded to nearest
  localparam logic signed [TW_W-1:0] TW_RE [N] = '{
     16'sd16384,  16'sd15137,  16'sd11585,  16'sd6270,
     16'sd0,     -16'sd6270,  -16'sd11585, -16'sd15137,
    -16'sd16384, -16'sd15137, -16'sd11585, -16'sd6270,
     16'sd0,      16'sd6270,   16'sd11585,  16'sd15137
  };

  // sin(2*pi*i/16) scaled by 2^14 and rounded to nearest (positive exponent: inverse transform)
  localparam logic signed [TW_W-1:0] TW_IM [N] = '{
     16'sd0,      16'sd6270,   16'sd11585,  16'sd15137,
     16'sd16384,  16'sd15137,  16'sd11585,  16'sd6270,
     16'sd0,     -16'sd6270,  -16'sd11585, -16'sd15137,
    -16'sd16384, -16'sd15137, -16'sd11585, -16'sd6270
  };

endpackage

// File: rtl/ifft16_cmac.sv
// Registered complex multiply-accumulate. When i_en is high the product
// x*w is added to the accumulator; i_clear restarts the sum from this product.
module ifft16_cmac #(
  parameter int DATA_WIDTH = 16,
  parameter int TW_W       = 16,
  parameter int ACC_W      = 2*DATA_WIDTH+6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_en,
  input  logic                           i_clear,
  input  logic signed [DATA_WIDTH-1:0]   i_xr,
  input  logic signed [DATA_WIDTH-1:0]   i_xi,
  input  logic signed [TW_W-1:0]         i_wr,
  input  logic signed [TW_W-1:0]         i_wi,
  output logic signed [ACC_W-1:0]        o_accRe,
  output logic signed [ACC_W-1:0]        o_accIm
);

  localparam int PROD_W = DATA_WIDTH + TW_W;

  logic signed [PROD_W-1:0] w_rr;
  logic signed [PROD_W-1:0] w_ii;
  logic signed [PROD_W-1:0] w_ri;
  logic signed [PROD_W-1:0] w_ir;
  logic signed [ACC_W-1:0]  w_termRe;
  logic signed [ACC_W-1:0]  w_termIm;
  logic signed [ACC_W-1:0]  r_accRe;
  logic signed [ACC_W-1:0]  r_accIm;

  assign w_rr = i_xr * i_wr;
  assign w_ii = i_xi * i_wi;
  assign w_ri = i_xr * i_wi;
  assign w_ir = i_xi * i_wr;

  assign w_termRe = ACC_W'(w_rr) - ACC_W'(w_ii);
  assign w_termIm = ACC_W'(w_ri) + ACC_W'(w_ir);

  // Accumulate one complex product per enabled cycle, restarting on clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_accRe <= '0;
      r_accIm <= '0;
    end else if (i_en) begin
      r_accRe <= (i_clear ? '0 : r_accRe) + w_termRe;
      r_accIm <= (i_clear ? '0 : r_accIm) + w_termIm;
    end
  end

  assign o_accRe = r_accRe;
  assign o_accIm = r_accIm;

endmodule

// File: rtl/ifft16_stream.sv
// Block 16-point complex inverse DFT on an I/Q sample stream.
// Collects 16 samples, evaluates each bin with 16 sequential complex MACs,
// then presents the scaled and saturated bin on the output handshake.
// Optional macro IFFT16_ROUND_EN: round-half-up before the output shift
// instead of plain truncation.
module ifft16_stream
  import ifft16_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CLIP_BITS  = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_tvalid,
  input  logic                         in_tlast,
  output logic                         in_tready,
  input  logic signed [DATA_WIDTH-1:0] in_itdata,
  input  logic signed [DATA_WIDTH-1:0] in_qtdata,
  output logic                         out_tvalid,
  output logic                         out_tlast,
  input  logic                         out_tready,
  output logic signed [DATA_WIDTH-1:0] out_itdata,
  output logic signed [DATA_WIDTH-1:0] out_qtdata
);

  localparam int ACC_W = 2*DATA_WIDTH + 6;
  localparam int SHIFT = 9 + CLIP_BITS;
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N-1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`ifdef IFFT16_ROUND_EN
  localparam logic signed [ACC_W-1:0] ROUND_ADD = ACC_W'(1) <<< (SHIFT-1);
`else
  localparam logic signed [ACC_W-1:0] ROUND_ADD = '0;
`endif

  state_t                        r_state;
  logic [LOG2N-1:0]              r_wrIdx;
  logic [LOG2N-1:0]              r_mIdx;
  logic [LOG2N-1:0]              r_k;
  logic                          r_inReady;
  logic                          r_outValid;
  logic                          r_outLast;
  logic signed [DATA_WIDTH-1:0]  r_outI;
  logic signed [DATA_WIDTH-1:0]  r_outQ;
  logic signed [DATA_WIDTH-1:0]  r_bufI [N];
  logic signed [DATA_WIDTH-1:0]  r_bufQ [N];

  logic                          w_inXfer;
  logic                          w_macEn;
  logic                          w_macClear;
  logic [LOG2N-1:0]              w_twIdx;
  logic signed [ACC_W-1:0]       w_accRe;
  logic signed [ACC_W-1:0]       w_accIm;
  logic signed [ACC_W-1:0]       w_sumRe;
  logic signed [ACC_W-1:0]       w_sumIm;
  logic signed [ACC_W-1:0]       w_shRe;
  logic signed [ACC_W-1:0]       w_shIm;
  logic                          w_unusedTlast;

  // Block boundaries come from the internal sample counter, so tlast is not needed
  assign w_unusedTlast = in_tlast;

  assign w_inXfer   = in_tvalid & r_inReady;
  assign w_macEn    = (r_state == CALC);
  assign w_macClear = (r_mIdx == '0);
  // (m*k) mod 16 falls out of keeping only the low four product bits
  assign w_twIdx    = r_mIdx * r_k;

  assign w_sumRe = w_accRe + ROUND_ADD;
  assign w_sumIm = w_accIm + ROUND_ADD;
  assign w_shRe  = w_sumRe >>> SHIFT;
  assign w_shIm  = w_sumIm >>> SHIFT;

  function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)
      saturate = SAT_MAX[DATA_WIDTH-1:0];
    else if (v < SAT_MIN)
      saturate = SAT_MIN[DATA_WIDTH-1:0];
    else
      saturate = v[DATA_WIDTH-1:0];
  endfunction

  ifft16_cmac #(
    .DATA_WIDTH (DATA_WIDTH),
    .TW_W       (TW_W),
    .ACC_W      (ACC_W)
  ) u_cmac (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_macEn),
    .i_clear (w_macClear),
    .i_xr    (r_bufI[r_mIdx]),
    .i_xi    (r_bufQ[r_mIdx]),
    .i_wr    (TW_RE[w_twIdx]),
    .i_wi    (TW_IM[w_twIdx]),
    .o_accRe (w_accRe),
    .o_accIm (w_accIm)
  );

  // Sample buffer written in arrival order while the block is filling
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        r_bufI[i] <= '0;
        r_bufQ[i] <= '0;
      end
    end else if (w_inXfer) begin
      r_bufI[r_wrIdx] <= in_itdata;
      r_bufQ[r_wrIdx] <= in_qtdata;
    end
  end

  // Block controller: fill 16 samples, then per bin 16 MAC cycles and one output slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= FILL;
      r_wrIdx    <= '0;
      r_mIdx     <= '0;
      r_k        <= '0;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
      r_outI     <= '0;
      r_outQ     <= '0;
    end else begin
      case (r_state)
        FILL: begin
          r_inReady <= 1'b1;
          if (w_inXfer) begin
            r_wrIdx <= r_wrIdx + 1'b1;
            if (r_wrIdx == LAST_IDX) begin
              r_state   <= CALC;
              r_k       <= '0;
              r_mIdx    <= '0;
              r_inReady <= 1'b0;
            end
          end
        end
        CALC: begin
          r_mIdx <= r_mIdx + 1'b1;
          if (r_mIdx == LAST_IDX)
            r_state <= OUT;
        end
        OUT: begin
          if (!r_outValid) begin
            r_outValid <= 1'b1;
            r_outLast  <= (r_k == LAST_IDX);
            r_outI     <= saturate(w_shRe);
            r_outQ     <= saturate(w_shIm);
          end else if (out_tready) begin
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            if (r_k == LAST_IDX) begin
              r_state   <= FILL;
              r_k       <= '0;
              r_inReady <= 1'b1;
            end else begin
              r_k     <= r_k + 1'b1;
              r_state <= CALC;
            end
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign in_tready  = r_inReady;
  assign out_tvalid = r_outValid;
  assign out_tlast  = r_outLast;
  assign out_itdata = r_outI;
  assign out_qtdata = r_outQ;

endmodule

// File: tb/tb_ifft16_stream.sv
// Directed bench for ifft16_stream: impulse, DC, tone with output stall,
// full-scale saturation (second instance with CLIP_BITS=0) and mid-block reset.
module tb_ifft16_stream;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_tvalid;
  logic               in_tlast;
  logic               in_tready;
  logic signed [15:0] in_itdata;
  logic signed [15:0] in_qtdata;
  logic               out_tvalid;
  logic               out_tlast;
  logic               out_tready;
  logic signed [15:0] out_itdata;
  logic signed [15:0] out_qtdata;

  logic               satInReady;
  logic               satOutValid;
  logic               satOutLast;
  logic signed [15:0] satOutI;
  logic signed [15:0] satOutQ;

  int checkCount = 0;
  int errorCount = 0;

  logic signed [15:0] stimI [16];
  logic signed [15:0] stimQ [16];
  int gotRe [16];
  int gotIm [16];
  int gotLast [16];
  int latency [2];
  int satRe0;
  int satIm0;
  int readyErrs;
  int syncErrs;

`ifdef IFFT16_ROUND_EN
  localparam int IMP_RE = 63;
  localparam int TONE_RE [16] = '{100, 92, 71, 38, 0, -38, -71, -92, -100, -92, -71, -38, 0, 38, 71, 92};
  localparam int TONE_IM [16] = '{0, 38, 71, 92, 100, 92, 71, 38, 0, -38, -71, -92, -100, -92, -71, -38};
`else
  localparam int IMP_RE = 62;
  localparam int TONE_RE [16] = '{100, 92, 70, 38, 0, -39, -71, -93, -100, -93, -71, -39, 0, 38, 70, 92};
  localparam int TONE_IM [16] = '{0, 38, 70, 92, 100, 92, 70, 38, 0, -39, -71, -93, -100, -93, -71, -39};
`endif

  always #5 clk = ~clk;

  ifft16_stream dut (
    .clk        (clk),
    .reset      (reset),
    .in_tvalid  (in_tvalid),
    .in_tlast   (in_tlast),
    .in_tready  (in_tready),
    .in_itdata  (in_itdata),
    .in_qtdata  (in_qtdata),
    .out_tvalid (out_tvalid),
    .out_tlast  (out_tlast),
    .out_tready (out_tready),
    .out_itdata (out_itdata),
    .out_qtdata (out_qtdata)
  );

  ifft16_stream #(.CLIP_BITS(0)) dutSat (
    .clk        (clk),
    .reset      (reset),
    .in_tvalid  (in_tvalid),
    .in_tlast   (in_tlast),
    .in_tready  (satInReady),
    .in_itdata  (in_itdata),
    .in_qtdata  (in_qtdata),
    .out_tvalid (satOutValid),
    .out_tlast  (satOutLast),
    .out_tready (out_tready),
    .out_itdata (satOutI),
    .out_qtdata (satOutQ)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Push the 16 samples in stimI/stimQ through the input handshake
  task automatic applyStimulus();
    int waitCnt;
    for (int i = 0; i < 16; i++) begin
      in_tvalid = 1'b1;
      in_itdata = stimI[i];
      in_qtdata = stimQ[i];
      in_tlast  = (i == 15);
      waitCnt   = 0;
      while (!in_tready && waitCnt < 400) begin
        @(negedge clk);
        waitCnt++;
      end
      if (waitCnt >= 400)
        checkOutput("inReadyTimeout", 0, 1);
      @(negedge clk);
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    in_itdata = '0;
    in_qtdata = '0;
  endtask

  // Receive numBins bins; optionally hold out_tready low for 50 cycles at stallBin
  task automatic collectBins(input int numBins, input int stallBin);
    int waitCnt;
    int stableErrs;
    out_tready = 1'b1;
    readyErrs  = 0;
    syncErrs   = 0;
    for (int b = 0; b < numBins; b++) begin
      waitCnt = 0;
      while (!out_tvalid && waitCnt < 400) begin
        @(negedge clk);
        waitCnt++;
        if (in_tready !== 1'b0 || satInReady !== 1'b0)
          readyErrs++;
      end
      if (waitCnt >= 400)
        checkOutput("outValidTimeout", 0, 1);
      if (b < 2)
        latency[b] = waitCnt;
      gotRe[b]   = out_itdata;
      gotIm[b]   = out_qtdata;
      gotLast[b] = int'(out_tlast);
      if (satOutValid !== out_tvalid || satOutLast !== out_tlast)
        syncErrs++;
      if (b == 0) begin
        satRe0 = satOutI;
        satIm0 = satOutQ;
      end
      if (b == stallBin) begin
        out_tready = 1'b0;
        stableErrs = 0;
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (int'(out_itdata) != gotRe[b] || int'(out_qtdata) != gotIm[b] ||
              out_tvalid !== 1'b1 || in_tready !== 1'b0)
            stableErrs++;
        end
        checkOutput("stallStable", stableErrs, 0);
        out_tready = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic loadImpulse();
    for (int i = 0; i < 16; i++) begin
      stimI[i] = (i == 0) ? 16'sd1000 : 16'sd0;
      stimQ[i] = 16'sd0;
    end
  endtask

  function automatic int withinOne(input int v);
    return (v >= -1 && v <= 1) ? 0 : v;
  endfunction

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b0;
    in_tvalid  = 1'b0;
    in_tlast   = 1'b0;
    in_itdata  = '0;
    in_qtdata  = '0;
    out_tready = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rstInReady", int'(in_tready), 0);
    checkOutput("rstOutValid", int'(out_tvalid), 0);
    checkOutput("rstOutLast", int'(out_tlast), 0);
    checkOutput("rstOutI", out_itdata, 0);
    checkOutput("rstOutQ", out_qtdata, 0);

    reset = 1'b1;
    #1;
    checkOutput("readyBeforeEdge", int'(in_tready), 0);
    @(negedge clk);
    checkOutput("readyAfterRelease", int'(in_tready), 1);

    $display("[TB] impulse block");
    loadImpulse();
    applyStimulus();
    collectBins(16, -1);
    checkOutput("impLatency0", latency[0], 17);
    checkOutput("impLatency1", latency[1], 17);
    for (int b = 0; b < 16; b++) begin
      checkOutput($sformatf("impRe%0d", b), gotRe[b], IMP_RE);
      checkOutput($sformatf("impIm%0d", b), gotIm[b], 0);
      checkOutput($sformatf("impLast%0d", b), gotLast[b], (b == 15) ? 1 : 0);
    end
    checkOutput("impReadyDuringCalc", readyErrs, 0);
    checkOutput("impReadyAfterBlock", int'(in_tready), 1);

    $display("[TB] DC block");
    for (int i = 0; i < 16; i++) begin
      stimI[i] = 16'sd1600;
      stimQ[i] = 16'sd0;
    end
    applyStimulus();
    collectBins(16, -1);
    checkOutput("dcRe0", gotRe[0], 1600);
    checkOutput("dcIm0", gotIm[0], 0);
    for (int b = 1; b < 16; b++) begin
      checkOutput($sformatf("dcRe%0d", b), withinOne(gotRe[b]), 0);
      checkOutput($sformatf("dcIm%0d", b), withinOne(gotIm[b]), 0);
    end

    $display("[TB] tone block with stall on bin 3");
    for (int i = 0; i < 16; i++) begin
      stimI[i] = (i == 1) ? 16'sd1600 : 16'sd0;
      stimQ[i] = 16'sd0;
    end
    applyStimulus();
    collectBins(16, 3);
    for (int b = 0; b < 16; b++) begin
      checkOutput($sformatf("toneRe%0d", b), gotRe[b], TONE_RE[b]);
      checkOutput($sformatf("toneIm%0d", b), gotIm[b], TONE_IM[b]);
    end
    checkOutput("toneLast15", gotLast[15], 1);
    checkOutput("toneReadyDuringCalc", readyErrs, 0);

    $display("[TB] full-scale saturation block");
    for (int i = 0; i < 16; i++) begin
      stimI[i] = 16'sd32767;
      stimQ[i] = -16'sd32768;
    end
    applyStimulus();
    collectBins(16, -1);
    checkOutput("satClip0Re0", satRe0, 32767);
    checkOutput("satClip0Im0", satIm0, -32768);
    checkOutput("fullScaleRe0", gotRe[0], 32767);
    checkOutput("fullScaleIm0", gotIm[0], -32768);
    checkOutput("fullScaleRe4", withinOne(gotRe[4]), 0);
    checkOutput("satReadyDuringCalc", readyErrs, 0);
    checkOutput("satInstanceSync", syncErrs, 0);

    $display("[TB] reset during bin 7");
    loadImpulse();
    applyStimulus();
    collectBins(7, -1);
    checkOutput("preResetRe6", gotRe[6], IMP_RE);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midRstOutValid", int'(out_tvalid), 0);
    checkOutput("midRstOutI", out_itdata, 0);
    checkOutput("midRstOutQ", out_qtdata, 0);
    checkOutput("midRstInReady", int'(in_tready), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("postRstReady", int'(in_tready), 1);
    loadImpulse();
    applyStimulus();
    collectBins(16, -1);
    checkOutput("postRstLatency0", latency[0], 17);
    checkOutput("postRstRe0", gotRe[0], IMP_RE);
    checkOutput("postRstIm0", gotIm[0], 0);
    checkOutput("postRstLast15", gotLast[15], 1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ifft16_stream.md
Name: ifft16_stream

Overview:
- Block 16-point complex inverse DFT on an AXI-Stream-style I/Q sample stream, DATA_WIDTH-bit signed I and Q.
- Collects 16 input samples into a buffer, then computes the 16 output bins sequentially with one complex MAC per cycle, using a constant twiddle ROM.
- Streams the bins out with a configurable output scaling shift and saturation.
- Sits between the frequency-domain mapper and the time-domain TX chain; longer frames, e.g. 512 samples, are handled as consecutive 16-sample blocks.

Parameters:
- DATA_WIDTH, 16, width of each signed I/Q component, in and out.
- CLIP_BITS, 9, sets the output right shift. Shift = 9 + CLIP_BITS. The default gives shift 18 = 14 twiddle fraction bits + log2(16), i.e. exact 1/N scaling. Legal range 0..(ACC_W-DATA_WIDTH-9).

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset (reset=0 resets)
- in_tvalid  in  1  input sample valid
- in_tlast  in  1  accepted and ignored; blocks are counted internally
- in_tready  out  1  block can accept a sample
- in_itdata  in  DATA_WIDTH  input I, signed
- in_qtdata  in  DATA_WIDTH  input Q, signed
- out_tvalid  out  1  output bin valid
- out_tlast  out  1  high on bin 15 of each block
- out_tready  in  1  downstream ready
- out_itdata  out  DATA_WIDTH  output I, signed
- out_qtdata  out  DATA_WIDTH  output Q, signed

Behaviour:
- Reset (reset=0, asynchronous): state=FILL, counters=0, accumulator=0, in_tready=0 for the duration of reset, out_tvalid=0, out_tlast=0, out data=0.
- in_tready=1 on the first clk edge after reset release.
- Input handshake: a transfer occurs when in_tvalid & in_tready. Samples x[0..15] are written to a 16-entry buffer in arrival order.
- FILL: in_tready=1. On the 16th transfer, go to CALC with bin k=0 and in_tready=0 from the next cycle.
- CALC: 16 cycles per bin. Cycle m accumulates x[m]·W[(m·k) mod 16], where W[i] = exp(+j·2π·i/16) is stored as Q2.14: re=round(16384·cos), im=round(16384·sin), 16-entry ROM.
  - Complex multiply: re = xr·wr − xi·wi, im = xr·wi + xi·wr.
  - Accumulator width ACC_W = 2·DATA_WIDTH+6, signed, cleared at the start of each bin.
  - After 16 MACs, go to OUT.
- OUT: out = saturate_DATA_WIDTH(acc >>> (9+CLIP_BITS)), arithmetic shift with truncation (floor). Saturation bounds are ±(2^(DATA_WIDTH−1)−1, −2^(DATA_WIDTH−1)).
  - Output registered with out_tvalid=1; out_tlast=(k==15).
  - Data and valid hold stable until out_tready=1.
  - On the handshake: if k<15, k++ and return to CALC; else go to FILL.
- Bin 0 is presented 17 cycles after the 16th input transfer. Each bin takes 17 cycles plus backpressure stall. Input stays blocked from the 16th input until bin 15 is handshaked.
- in_tvalid while in_tready=0 is ignored; no sample is lost on the block's side.
- Reset mid-block discards the buffer and any partial output.

Optional Feature:
- Macro IFFT16_ROUND_EN.
- Defined: add 2^(8+CLIP_BITS) to the accumulator before the shift, giving round-half-up.
- Undefined: plain truncation as above.
- Saturation applies in both cases.

Decomposition:
- Package ifft16_pkg: N=16, LOG2N=4, TW_FRAC=14, state encoding (FILL, CALC, OUT), 16-entry twiddle constant arrays.
- One natural sub-module, ifft16_cmac: registered complex multiply-accumulate with clear.

Test Plan:
- Impulse: x[0]=(1000,0), others 0 → all 16 bins = (62,0); with IFFT16_ROUND_EN, (63,0); out_tlast only on bin 15.
- DC: all x=(1600,0) → bin0=(1600,0); bins 1..15 within ±1 of (0,0).
- Tone: x[1]=(1600,0), others 0 → bin n ≈ (100·cos(2πn/16), 100·sin(2πn/16)); bin4=(0,100), bin8=(−100,0), bin12=(0,−100), each ±1.
- Saturation: CLIP_BITS=0, all x=(32767,−32768) → bin0=(32767,−32768); in_tready=0 throughout CALC/OUT.
- Backpressure: hold out_tready=0 for 50 cycles at bin 3 → bin 3 data and out_tvalid stable, no bins skipped, in_tready stays 0.
- Reset: assert reset during CALC of bin 7 → outputs zero immediately; after release, a fresh impulse block gives the correct first result.
